// File: rtl/comb_pkg.sv
// Shared switch encodings, default combination and sequencer state type
// for the combination-lock sequencer.
package comb_pkg;

    localparam logic [2:0]  SW_IDLE      = 3'b111;
    localparam logic [2:0]  SW_A         = 3'b011;
    localparam logic [2:0]  SW_B         = 3'b101;
    localparam logic [2:0]  SW_C         = 3'b110;
    localparam logic [11:0] DEFAULT_CODE = {SW_B, SW_C, SW_A, SW_B};
    localparam int          TIMER_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS,
        ST_GAP,
        ST_WAIT_LED,
        ST_DONE
    } seq_state_t;

    // Step 0 lives in the most significant triplet.
    function automatic logic [2:0] code_step(input logic [11:0] code, input logic [1:0] step);
        logic [2:0] r;
        case (step)
            2'd0:    r = code[11:9];
            2'd1:    r = code[8:6];
            2'd2:    r = code[5:3];
            default: r = code[2:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/comb_timer.sv
// Loadable 8-bit down-counter; expiry is flagged while the count sits at 1.
module comb_timer
    import comb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    output logic               o_expired
);

    logic [TIMER_W-1:0] r_count;

    // Stops at zero rather than wrapping so a stale count never re-expires.
    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (r_count != '0)
            r_count <= r_count - 1'b1;
    end

    assign o_expired = (r_count == TIMER_W'(1));

endmodule

// File: rtl/comb_sequencer.sv
// Plays a stored four-step switch code into a combination lock and reports
// whether the lock's LED came on before the timeout.
module comb_sequencer
    import comb_pkg::*;
#(
    parameter int HOLD_CYCLES    = 1,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        code_load,
    input  logic [11:0] code_in,
    input  logic        led_in,
    output logic [2:0]  switch,
    output logic        busy,
    output logic        done,
    output logic        unlocked
);

    localparam logic [TIMER_W-1:0] L_HOLD    = TIMER_W'(HOLD_CYCLES);
    localparam logic [TIMER_W-1:0] L_GAP     = TIMER_W'(GAP_CYCLES);
    localparam logic [TIMER_W-1:0] L_TIMEOUT = TIMER_W'(TIMEOUT_CYCLES);

    seq_state_t         r_state, w_state_next;
    logic [1:0]         r_step, w_step_next;
    logic [11:0]        r_code;
    logic               r_unlocked, w_unlocked_next;
    logic               w_tmr_load;
    logic [TIMER_W-1:0] w_tmr_val;
    logic               w_tmr_exp;

    comb_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expired  (w_tmr_exp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_step     <= 2'd0;
            r_unlocked <= 1'b0;
            r_code     <= DEFAULT_CODE;
        end else begin
            r_state    <= w_state_next;
            r_step     <= w_step_next;
            r_unlocked <= w_unlocked_next;
            // Loading in the start cycle means the new code is what gets played.
            if (r_state == ST_IDLE && code_load)
                r_code <= code_in;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_step_next     = r_step;
        w_unlocked_next = r_unlocked;
        w_tmr_load      = 1'b0;
        w_tmr_val       = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next    = ST_PRESS;
                    w_step_next     = 2'd0;
                    w_unlocked_next = 1'b0;
                    w_tmr_load      = 1'b1;
                    w_tmr_val       = L_HOLD;
                end
            end
            ST_PRESS: begin
                if (w_tmr_exp) begin
                    w_tmr_load = 1'b1;
                    if (r_step != 2'd3) begin
                        w_state_next = ST_GAP;
                        w_tmr_val    = L_GAP;
                    end else begin
                        w_state_next = ST_WAIT_LED;
                        w_tmr_val    = L_TIMEOUT;
                    end
                end
            end
            ST_GAP: begin
                if (w_tmr_exp) begin
                    w_state_next = ST_PRESS;
                    w_step_next  = r_step + 2'd1;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = L_HOLD;
                end
            end
            ST_WAIT_LED: begin
                if (led_in) begin
                    w_state_next    = ST_DONE;
                    w_unlocked_next = 1'b1;
                end else if (w_tmr_exp) begin
                    w_state_next    = ST_DONE;
                    w_unlocked_next = 1'b0;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign switch   = (r_state == ST_PRESS) ? code_step(r_code, r_step) : SW_IDLE;
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign unlocked = r_unlocked;

endmodule

// File: doc/comb_sequencer.md
COMB_SEQUENCER -- requirements
Module: comb_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 1, sets press duration in clk cycles per code step (range 1..15).
REQ-002 Parameter GAP_CYCLES, default 2, sets idle (3'b111) cycles between steps (range 1..15).
REQ-003 Parameter TIMEOUT_CYCLES, default 8, sets cycles to wait for unlock feedback after the last step (range 1..255).
REQ-004 clk  input  1  sole clock; all state changes on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-006 start  input  1  one-cycle request to play the stored code; honoured only in IDLE.
REQ-007 code_load  input  1  loads code_in into the code register; honoured only in IDLE.
REQ-008 code_in  input  12  four 3-bit steps: [11:9] step0, [8:6] step1, [5:3] step2, [2:0] step3.
REQ-009 led_in  input  1  unlock indication from the lock under test.
REQ-010 switch  output  3  active-low switch drive to the lock; 3'b111 = no switch pressed.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at end of a sequence.
REQ-013 unlocked  output  1  result of last sequence; valid from the done pulse until the next accepted start.

Function
REQ-014 States: IDLE, PRESS, GAP, WAIT_LED, DONE; all outputs registered or decoded from registered state only.
REQ-015 IDLE: switch=3'b111, busy=0; start=1 -> PRESS with step index 0, timer loaded with HOLD_CYCLES, unlocked cleared.
REQ-016 PRESS: switch=code[step]; after HOLD_CYCLES cycles -> GAP if step<3 (timer=GAP_CYCLES), else WAIT_LED (timer=TIMEOUT_CYCLES).
REQ-017 GAP: switch=3'b111; after GAP_CYCLES cycles -> PRESS with step+1, timer=HOLD_CYCLES.
REQ-018 WAIT_LED: switch=3'b111; led_in=1 on any cycle -> DONE with unlocked=1; timer expiry with led_in=0 -> DONE with unlocked=0.
REQ-019 led_in is also sampled in the last PRESS cycle; a 1 there still requires entry to WAIT_LED, then DONE on the first WAIT_LED cycle if led_in remains 1.
REQ-020 DONE: done=1, switch=3'b111, busy=1 for exactly one cycle, then IDLE.
REQ-021 Total play length = 4*HOLD_CYCLES + 3*GAP_CYCLES cycles from the cycle after start to the first WAIT_LED cycle.
REQ-022 start or code_load while busy=1 is ignored; code register and sequence unaffected.
REQ-023 start and code_load in the same IDLE cycle: code_in is loaded and the sequence plays the newly loaded code.
REQ-024 Step values are played verbatim, including 3'b111 (a silent step) and values with multiple zeros.
REQ-025 Timer is a down-counter, width 8 bits; no wrap-around; expiry = count reaching 1 in the current state.

Reset
REQ-026 reset=1 forces IDLE, step=0, timer=0, switch=3'b111, busy=0, done=0, unlocked=0 on the next posedge, including mid-sequence.
REQ-027 Code register resets to 12'b101_110_011_101 (B, C, A, B).
REQ-028 reset takes priority over start and code_load in the same cycle.

Structure
REQ-029 Shared package comb_pkg holds SW_IDLE=3'b111, SW_A=3'b011, SW_B=3'b101, SW_C=3'b110, DEFAULT_CODE, and the sequencer state enum.
REQ-030 One sub-module comb_timer (load value, load strobe, expired flag) implements the down-counter; FSM and code register stay in comb_sequencer.

Verification
REQ-031 Reset, defaults, start pulse -> switch shows 101 (1 cycle), 111x2, 110, 111x2, 011, 111x2, 101, then 111; busy high throughout.
REQ-032 Default code driving the team's combination-lock FSM in the bench -> led_in rises, done pulses with unlocked=1 within 3 cycles of WAIT_LED entry.
REQ-033 code_load with 12'b101_110_110_101 then start against the lock -> led_in stays 0, done pulses after 8 WAIT_LED cycles, unlocked=0.
REQ-034 start and code_load asserted during GAP of step 1 -> sequence and stored code unchanged; following start plays the original code.
REQ-035 reset asserted in PRESS of step 2 -> next cycle switch=111, busy=0, done=0, code register = DEFAULT_CODE.
REQ-036 code_load and start in the same IDLE cycle with 12'b011_011_011_011 -> four presses of 011 played.
